// File: rtl/src_cb_pkg.sv
// Shared state encoding and the F(arr) kernel for the CBF source/target program model.
package src_cb_pkg;

  typedef enum logic [2:0] {
    S_LATCH  = 3'd0,
    S_BRANCH = 3'd1,
    S_A_T    = 3'd2,
    S_B_T    = 3'd3,
    S_A_F    = 3'd4,
    S_B_F    = 3'd5,
    S_DONE   = 3'd6,
    S_A_H    = 3'd7
  } state_e;

  localparam int CB_MAXW = 32;

  // 2*(arr0+1)*((arr1-1)%2): the modulo term is just ~arr1[0], so F is a shifted
  // increment or zero. Operands are zero-extended; callers truncate to DW+2 bits.
  function automatic logic [CB_MAXW+1:0] cb_f(input logic [CB_MAXW-1:0] arr0,
                                              input logic [CB_MAXW-1:0] arr1);
    logic [CB_MAXW:0] inc;
    inc = {1'b0, arr0} + 1'b1;
    return arr1[0] ? '0 : {inc, 1'b0};
  endfunction

endpackage

// File: rtl/cb_array_read.sv
// Combinational array element select; indices at or beyond DEPTH read as zero.
module cb_array_read #(
  parameter int DW    = 2,
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH) + 1
) (
  input  logic [IW-1:0]       idx,
  input  logic [DEPTH*DW-1:0] arr,
  output logic [DW-1:0]       data
);

  always_comb begin
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (idx == IW'(k)) data = arr[k*DW +: DW];
    end
  end

endmodule

// File: rtl/param_source_codeblock.sv
// CBF source-program model: branchy a/b computation stepped one state per unstuttered clock.
// Define CBF_HOIST_EN to build the hoisted (target) program, where a = F is computed before the branch.
import src_cb_pkg::*;

module param_source_codeblock #(
  parameter int DW    = 2,
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stutter_in,
  input  logic                start,
  input  logic [IW-1:0]       j,
  input  logic [IW-1:0]       arr_size,
  input  logic [DEPTH*DW-1:0] arr,
  output logic [DW+1:0]       a,
  output logic [DW-1:0]       b,
  output logic                stutter,
  output logic                done,
  output logic [2:0]          pc
);

  state_e              state_q, state_d;
  logic [IW-1:0]       j_q, j_d, size_q, size_d;
  logic [DEPTH*DW-1:0] arr_q, arr_d;
  logic [DW+1:0]       a_q, a_d;
  logic [DW-1:0]       b_q, b_d;
  logic                done_q, done_d;
  logic                stutter_q;
  logic [IW-1:0]       rd_idx;
  logic [DW-1:0]       rd_data;
  logic                take_true;

  // Only the B states read the array; S_B_T uses j, everything else the bound.
  assign rd_idx    = (state_q == S_B_T) ? j_q : size_q;
  assign take_true = (j_q <= size_q);

  cb_array_read #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_rd (
    .idx  (rd_idx),
    .arr  (arr_q),
    .data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    size_d  = size_q;
    arr_d   = arr_q;
    a_d     = a_q;
    b_d     = b_q;
    if (!stutter_in) begin
      case (state_q)
        S_LATCH: begin
          j_d    = j;
          size_d = arr_size;
          arr_d  = arr;
`ifdef CBF_HOIST_EN
          state_d = S_A_H;
`else
          state_d = S_BRANCH;
`endif
        end
        S_BRANCH: begin
`ifdef CBF_HOIST_EN
          state_d = take_true ? S_B_T : S_B_F;
`else
          state_d = take_true ? S_A_T : S_A_F;
`endif
        end
        S_A_T: begin
          a_d     = (DW+2)'(cb_f(CB_MAXW'(arr_q[DW-1:0]), CB_MAXW'(arr_q[2*DW-1:DW])));
          state_d = S_B_T;
        end
        S_A_F: begin
          a_d     = (DW+2)'(cb_f(CB_MAXW'(arr_q[DW-1:0]), CB_MAXW'(arr_q[2*DW-1:DW])));
          state_d = S_B_F;
        end
        S_B_T, S_B_F: begin
          b_d     = rd_data;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (start) state_d = S_LATCH;
        end
        S_A_H: begin
`ifdef CBF_HOIST_EN
          a_d     = (DW+2)'(cb_f(CB_MAXW'(arr_q[DW-1:0]), CB_MAXW'(arr_q[2*DW-1:DW])));
          state_d = S_BRANCH;
`else
          state_d = S_DONE;
`endif
        end
      endcase
    end
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LATCH;
      j_q       <= '0;
      size_q    <= '0;
      arr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      done_q    <= 1'b0;
      stutter_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      size_q    <= size_d;
      arr_q     <= arr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      done_q    <= done_d;
      stutter_q <= stutter_in;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign done    = done_q;
  assign stutter = stutter_q;
  assign pc      = state_q;

endmodule
